or1200_vlx_ctrl: RTL and testbench

Sequencer for the set-bit (SBIT) store path of the load/store unit. Accepts variable-length bit fields from SBIT instructions, packs them MSB-first into a 32-bit bit buffer, and drains whole bytes to the data cache one byte-store at a time over the dcpu handshake. It optionally inserts JPEG 0xFF->0x00 stuffing and supports an SPR-triggered flush. It stalls the CPU while a drain is in progress, so the LSU port is never contended.

---
 rtl/or1200_vlx_ctrl.sv | 122 ++++++++++++
 tb/tb_or1200_vlx_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/or1200_vlx_ctrl.sv
// or1200_vlx_ctrl: packs SBIT bit fields MSB-first and drains them as byte stores,
// with optional JPEG 0xFF byte stuffing and SPR-triggered flush of a partial byte.
module or1200_vlx_ctrl #(
    parameter logic SPR_STUFF_DEFAULT = 1'b1,
    parameter logic PAD_BIT = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        set_bit_op_i,
    input  logic [4:0]  num_bits_to_write_i,
    input  logic [15:0] dat_i,
    input  logic        ack_i,
    output logic        store_byte_o,
    output logic [31:0] vlx_addr_o,
    output logic [31:0] dat_o,
    output logic        stall_cpu_o,
    input  logic        spr_cs,
    input  logic        spr_write,
    input  logic [1:0]  spr_addr,
    input  logic [31:0] spr_dat_i,
    output logic [31:0] spr_dat_o
);
    typedef enum logic [1:0] {IDLE, STORE, STUFF, FLUSH} state_t;
    state_t state, n_state, after_byte;
    logic [31:0] bitbuf, n_bitbuf, addr, n_addr, bytecnt, n_bytecnt;
    logic [31:0] field, pad_mask, sh_buf;
    logic [5:0] count, n_count, sh_count;
    logic [4:0] len;
    logic stuff_en, n_stuff_en, flush_pend, n_flush_pend, accept, spr_wr;

    assign len = num_bits_to_write_i > 5'd16 ? 5'd16 : num_bits_to_write_i;
    assign accept = set_bit_op_i && state == IDLE && len != 5'd0;
    assign field = (({16'b0, dat_i} & ((32'd1 << len) - 32'd1)) << (6'd32 - {1'b0, len})) >> count;
    assign pad_mask = (32'hFF00_0000 >> count) & 32'hFF00_0000;
    assign sh_buf = bitbuf << 8;
    assign sh_count = count - 6'd8;
    assign after_byte = sh_count >= 6'd8 ? STORE : (flush_pend && sh_count != 6'd0) ? FLUSH : IDLE;
    assign spr_wr = spr_cs && spr_write;
    assign vlx_addr_o = addr;
    assign spr_dat_o = spr_addr == 2'd0 ? addr :
                       spr_addr == 2'd1 ? {18'b0, count, 5'b0, state != IDLE, flush_pend, stuff_en} :
                       spr_addr == 2'd2 ? bitbuf : bytecnt;

    always_comb begin
        n_state = state;
        n_bitbuf = bitbuf;
        n_count = count;
        n_addr = addr;
        n_bytecnt = bytecnt;
        n_stuff_en = stuff_en;
        n_flush_pend = flush_pend;
        case (state)
            IDLE: begin
                if (accept) begin
                    n_bitbuf = bitbuf | field;
                    n_count = count + {1'b0, len};
                end
                // a same-cycle append keeps the flush pending so it covers the new bits
                if (count >= 6'd8) n_state = STORE;
                else if (flush_pend && count != 6'd0) n_state = FLUSH;
                else if (flush_pend && !accept) n_flush_pend = 1'b0;
            end
            FLUSH: begin
                n_bitbuf = PAD_BIT ? bitbuf | pad_mask : bitbuf & ~pad_mask;
                n_count = 6'd8;
                n_flush_pend = 1'b0;
                n_state = STORE;
            end
            STORE: if (ack_i) begin
                n_addr = addr + 32'd1;
                n_bytecnt = bytecnt + 32'd1;
                if (bitbuf[31:24] == 8'hFF && stuff_en) n_state = STUFF;
                else begin
                    n_bitbuf = sh_buf;
                    n_count = sh_count;
                    n_state = after_byte;
                end
            end
            default: if (ack_i) begin
                n_addr = addr + 32'd1;
                n_bytecnt = bytecnt + 32'd1;
                n_bitbuf = sh_buf;
                n_count = sh_count;
                n_state = after_byte;
            end
        endcase
        if (spr_wr && spr_addr == 2'd0 && state == IDLE) n_addr = spr_dat_i;
        if (spr_wr && spr_addr == 2'd1) begin
            n_stuff_en = spr_dat_i[0];
            if (spr_dat_i[1]) n_flush_pend = 1'b1;
        end
        if (spr_wr && spr_addr == 2'd3) n_bytecnt = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            bitbuf <= '0;
            count <= '0;
            addr <= '0;
            bytecnt <= '0;
            stuff_en <= SPR_STUFF_DEFAULT;
            flush_pend <= 1'b0;
            store_byte_o <= 1'b0;
            dat_o <= '0;
            stall_cpu_o <= 1'b0;
        end else begin
            state <= n_state;
            bitbuf <= n_bitbuf;
            count <= n_count;
            addr <= n_addr;
            bytecnt <= n_bytecnt;
            stuff_en <= n_stuff_en;
            flush_pend <= n_flush_pend;
            store_byte_o <= n_state == STORE || n_state == STUFF;
            dat_o <= n_state == STORE ? {24'b0, n_bitbuf[31:24]} : 32'b0;
            stall_cpu_o <= n_state != IDLE;
        end
    end

    sbit_only_when_idle: assert property (@(posedge clk_i) disable iff (rst_i) set_bit_op_i |-> state == IDLE);
endmodule

// File: tb/tb_or1200_vlx_ctrl.sv
// tb_or1200_vlx_ctrl: bit-stream model predicts every byte store; directed SBIT/SPR vectors.
module tb_or1200_vlx_ctrl;
    logic clk_i = 0, rst_i = 1, set_bit_op_i = 0, ack_i = 0;
    logic [4:0] num_bits_to_write_i = 0;
    logic [15:0] dat_i = 0;
    logic store_byte_o, stall_cpu_o;
    logic [31:0] vlx_addr_o, dat_o, spr_dat_o;
    logic spr_cs = 0, spr_write = 0;
    logic [1:0] spr_addr = 0;
    logic [31:0] spr_dat_i = 0;

    or1200_vlx_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .set_bit_op_i(set_bit_op_i),
        .num_bits_to_write_i(num_bits_to_write_i), .dat_i(dat_i), .ack_i(ack_i),
        .store_byte_o(store_byte_o), .vlx_addr_o(vlx_addr_o), .dat_o(dat_o),
        .stall_cpu_o(stall_cpu_o), .spr_cs(spr_cs), .spr_write(spr_write),
        .spr_addr(spr_addr), .spr_dat_i(spr_dat_i), .spr_dat_o(spr_dat_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0, n_pass = 0;
    int ack_wait = 0;
    logic ack_en = 1;
    bit mq[$];
    logic [31:0] exp_a[$];
    logic [7:0] exp_d[$];
    logic [31:0] maddr = 0;
    logic mstuff = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // model: a plain bit queue; every full byte becomes an expected (address, data) store
    task automatic m_drain();
        logic [7:0] b;
        while (mq.size() >= 8) begin
            b = 0;
            for (int i = 0; i < 8; i++) b = {b[6:0], mq.pop_front()};
            exp_a.push_back(maddr); exp_d.push_back(b); maddr++;
            if (b == 8'hFF && mstuff) begin
                exp_a.push_back(maddr); exp_d.push_back(8'h00); maddr++;
            end
        end
    endtask

    task automatic m_append(input int len, input logic [15:0] d);
        int n = len > 16 ? 16 : len;
        for (int i = n - 1; i >= 0; i--) mq.push_back(d[i]);
        m_drain();
    endtask

    task automatic m_flush();
        if (mq.size() > 0) while (mq.size() < 8) mq.push_back(1'b1);
        m_drain();
    endtask

    task automatic sbit(input int len, input logic [15:0] d);
        set_bit_op_i = 1; num_bits_to_write_i = 5'(len); dat_i = d;
        m_append(len, d);
        @(negedge clk_i);
        set_bit_op_i = 0;
    endtask

    task automatic spr_wr(input logic [1:0] a, input logic [31:0] d);
        spr_cs = 1; spr_write = 1; spr_addr = a; spr_dat_i = d;
        @(negedge clk_i);
        spr_cs = 0; spr_write = 0;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        spr_cs = 1; spr_write = 0; spr_addr = a;
        #1 chk(name, spr_dat_o, exp);
        spr_cs = 0;
    endtask

    task automatic wait_idle();
        int t = 0;
        repeat (2) @(negedge clk_i);
        while ((stall_cpu_o || store_byte_o) && t < 200) begin
            @(negedge clk_i); t++;
        end
        chk("idle_timeout", 32'(t < 200), 32'd1);
        chk("drained", exp_d.size(), 0);
    endtask

    // bus responder and per-cycle store checker
    initial begin
        int wc = 0;
        forever begin
            @(negedge clk_i);
            ack_i = 0;
            if (rst_i) wc = 0;
            else if (store_byte_o) begin
                if (exp_d.size() == 0) chk("unexpected_store", dat_o, 32'hxxxx_xxxx);
                else begin
                    chk("store_data", dat_o, {24'b0, exp_d[0]});
                    chk("store_addr", vlx_addr_o, exp_a[0]);
                    chk("stall_in_store", stall_cpu_o, 1);
                    if (ack_en && wc == ack_wait) begin
                        ack_i = 1; wc = 0;
                        void'(exp_a.pop_front()); void'(exp_d.pop_front());
                    end else wc++;
                end
            end else wc = 0;
        end
    end

    initial begin
        int t;
        repeat (3) @(negedge clk_i);
        chk("rst_store", store_byte_o, 0);
        chk("rst_stall", stall_cpu_o, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_addr", vlx_addr_o, 0);
        rd_chk("rst_ctrl", 1, 32'h1);
        rst_i = 0;
        @(negedge clk_i);
        // three bytes at base 0x1000, with latency pinned on the first
        ack_wait = 1;
        spr_wr(0, 32'h1000); maddr = 32'h1000;
        sbit(8, 16'h12);
        chk("lat_idle", store_byte_o, 0);
        @(negedge clk_i);
        chk("lat_store", store_byte_o, 1);
        chk("lat_data", dat_o, 32'h12);
        wait_idle();
        sbit(8, 16'h34); wait_idle();
        sbit(8, 16'h56); wait_idle();
        rd_chk("bytecnt3", 3, 32'd3);
        rd_chk("addr_1003", 0, 32'h1003);
        // stuffing with two wait cycles per ack
        spr_wr(3, 0);
        spr_wr(0, 32'h2000); maddr = 32'h2000;
        spr_wr(1, 1); mstuff = 1;
        ack_wait = 2;
        sbit(16, 16'hFFA0);
        @(negedge clk_i);
        t = 0;
        while (stall_cpu_o && t < 100) begin
            chk("stuff_store_hi", store_byte_o, 1);
            @(negedge clk_i); t++;
        end
        chk("stall_cycles", t, 9);
        wait_idle();
        rd_chk("bytecnt_stuff", 3, 32'd3);
        // partial byte plus flush
        ack_wait = 0;
        sbit(5, 16'b10110);
        @(negedge clk_i);
        rd_chk("count5", 1, 32'h501);
        spr_wr(1, 32'h3); m_flush();
        chk("flush_byte", exp_d[0], 8'hB7);
        wait_idle();
        rd_chk("after_flush", 1, 32'h1);
        // zero length then clamped length
        sbit(0, 16'hFFFF);
        repeat (3) begin
            chk("len0_store", store_byte_o, 0);
            chk("len0_stall", stall_cpu_o, 0);
            @(negedge clk_i);
        end
        rd_chk("len0_ctrl", 1, 32'h1);
        sbit(20, 16'hABCD);
        chk("clamp_hi", exp_d[0], 8'hAB);
        chk("clamp_lo", exp_d[1], 8'hCD);
        wait_idle();
        // append and flush in the same cycle
        set_bit_op_i = 1; num_bits_to_write_i = 3; dat_i = 16'b010;
        spr_cs = 1; spr_write = 1; spr_addr = 1; spr_dat_i = 32'h3;
        m_append(3, 16'b010); m_flush();
        @(negedge clk_i);
        set_bit_op_i = 0; spr_cs = 0; spr_write = 0;
        wait_idle();
        rd_chk("simul_flush_ctrl", 1, 32'h1);
        // base write while busy is ignored
        spr_wr(0, 32'h4000); maddr = 32'h4000;
        ack_wait = 3;
        sbit(16, 16'h1122);
        @(negedge clk_i);
        chk("busy_stall", stall_cpu_o, 1);
        spr_wr(0, 32'h9000);
        wait_idle();
        rd_chk("addr_4002", 0, 32'h4002);
        // reset while a store waits for ack
        ack_en = 0;
        sbit(8, 16'h77);
        t = 0;
        while (!store_byte_o && t < 20) begin
            @(negedge clk_i); t++;
        end
        chk("store_started", store_byte_o, 1);
        repeat (2) @(negedge clk_i);
        rst_i = 1;
        @(negedge clk_i);
        chk("rstmid_store", store_byte_o, 0);
        chk("rstmid_stall", stall_cpu_o, 0);
        chk("rstmid_addr", vlx_addr_o, 0);
        rd_chk("rstmid_ctrl", 1, 32'h1);
        exp_a.delete(); exp_d.delete(); mq.delete(); maddr = 0; mstuff = 1;
        rst_i = 0; ack_en = 1;
        repeat (2) @(negedge clk_i);
        chk("post_rst_quiet", store_byte_o, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
